// File: rtl/rs_alu_station_if.sv
// rs_alu_station_if: dispatch, writeback, issue and flush signals for the
// ALU reservation station. The master side is dispatch/ALU, the slave side
// is the station itself.
interface rs_alu_station_if #(
   parameter int ENT_NUM   = 8,
   parameter int WB_NUM    = 3,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 6,
   parameter int PAYLOAD_W = 72
);
   localparam int CNT_W = $clog2(ENT_NUM + 1);

   logic                      i_flush;
   logic                      i_wr_en;
   logic [PAYLOAD_W-1:0]      i_wr_payload;
   logic                      i_wr_rs1_vld;
   logic                      i_wr_rs2_vld;
   logic [DATA_W-1:0]         i_wr_rs1;
   logic [DATA_W-1:0]         i_wr_rs2;
   logic [TAG_W-1:0]          i_wr_rrftag;
   logic                      o_full;
   logic [CNT_W-1:0]          o_free_cnt;
   logic [WB_NUM-1:0]         i_wb_vld;
   logic [WB_NUM*TAG_W-1:0]   i_wb_tag;
   logic [WB_NUM*DATA_W-1:0]  i_wb_data;
   logic                      o_iss_vld;
   logic                      i_iss_rdy;
   logic [PAYLOAD_W-1:0]      o_iss_payload;
   logic [DATA_W-1:0]         o_iss_rs1;
   logic [DATA_W-1:0]         o_iss_rs2;
   logic [TAG_W-1:0]          o_iss_rrftag;

   modport master (
      output i_flush, i_wr_en, i_wr_payload, i_wr_rs1_vld, i_wr_rs2_vld,
             i_wr_rs1, i_wr_rs2, i_wr_rrftag, i_wb_vld, i_wb_tag, i_wb_data,
             i_iss_rdy,
      input  o_full, o_free_cnt, o_iss_vld, o_iss_payload, o_iss_rs1,
             o_iss_rs2, o_iss_rrftag
   );

   modport slave (
      input  i_flush, i_wr_en, i_wr_payload, i_wr_rs1_vld, i_wr_rs2_vld,
             i_wr_rs1, i_wr_rs2, i_wr_rrftag, i_wb_vld, i_wb_tag, i_wb_data,
             i_iss_rdy,
      output o_full, o_free_cnt, o_iss_vld, o_iss_payload, o_iss_rs1,
             o_iss_rs2, o_iss_rrftag
   );
endinterface

// File: rtl/rs_alu_station.sv
// rs_alu_station: multi-entry ALU reservation station.
// Holds up to ENT_NUM dispatched ops, wakes pending operands from WB_NUM
// writeback ports (lowest port wins on multiple matches) and offers one
// ready entry per cycle to the ALU. Issue outputs depend on registers only.
// Optional macro RS_AGE_SEL_EN: oldest-first selection via an age matrix;
// when undefined the lowest-index ready entry is selected.
module rs_alu_station #(
   parameter int ENT_NUM   = 8,
   parameter int WB_NUM    = 3,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 6,
   parameter int PAYLOAD_W = 72
) (
   input  logic                clk,
   input  logic                rst_n,
   rs_alu_station_if.slave     bus
);
   localparam int CNT_W = $clog2(ENT_NUM + 1);

   logic [ENT_NUM-1:0]   busy_reg;
   logic [ENT_NUM-1:0]   rs1_vld_reg;
   logic [ENT_NUM-1:0]   rs2_vld_reg;
   logic [DATA_W-1:0]    rs1_reg     [ENT_NUM];
   logic [DATA_W-1:0]    rs2_reg     [ENT_NUM];
   logic [PAYLOAD_W-1:0] payload_reg [ENT_NUM];
   logic [TAG_W-1:0]     rrftag_reg  [ENT_NUM];

   logic [ENT_NUM-1:0]   ready;
   logic [ENT_NUM-1:0]   alloc_oh;
   logic [ENT_NUM-1:0]   sel_oh;
   logic                 alloc_ok;
   logic                 iss_vld;
   logic                 iss_fire;
   logic [CNT_W-1:0]     free_cnt;
   logic [DATA_W:0]      wake1 [ENT_NUM];
   logic [DATA_W:0]      wake2 [ENT_NUM];
   logic [DATA_W:0]      byp1;
   logic [DATA_W:0]      byp2;
   logic [PAYLOAD_W-1:0] iss_payload;
   logic [DATA_W-1:0]    iss_rs1;
   logic [DATA_W-1:0]    iss_rs2;
   logic [TAG_W-1:0]     iss_rrftag;

   // Returns {hit, data} for a tag against all valid writeback ports.
   // Scanning from the top port down lets the lowest matching port win.
   function automatic logic [DATA_W:0] wb_lookup(
      input logic [TAG_W-1:0]          tag,
      input logic [WB_NUM-1:0]         vld,
      input logic [WB_NUM*TAG_W-1:0]   tags,
      input logic [WB_NUM*DATA_W-1:0]  data
   );
      logic [DATA_W:0] res;
      res = '0;
      for (int k = WB_NUM - 1; k >= 0; k--) begin
         if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
            res = {1'b1, data[k*DATA_W +: DATA_W]};
         end
      end
      return res;
   endfunction

   genvar gi;

   // Per-entry wakeup lookups and ready flags
   generate
      for (gi = 0; gi < ENT_NUM; gi++) begin : g_wake
         assign wake1[gi] = wb_lookup(rs1_reg[gi][TAG_W-1:0], bus.i_wb_vld,
                                      bus.i_wb_tag, bus.i_wb_data);
         assign wake2[gi] = wb_lookup(rs2_reg[gi][TAG_W-1:0], bus.i_wb_vld,
                                      bus.i_wb_tag, bus.i_wb_data);
         assign ready[gi] = busy_reg[gi] & rs1_vld_reg[gi] & rs2_vld_reg[gi];
      end
   endgenerate

   // Bypass for operands that arrive pending while their producer writes back
   assign byp1 = wb_lookup(bus.i_wr_rs1[TAG_W-1:0], bus.i_wb_vld,
                           bus.i_wb_tag, bus.i_wb_data);
   assign byp2 = wb_lookup(bus.i_wr_rs2[TAG_W-1:0], bus.i_wb_vld,
                           bus.i_wb_tag, bus.i_wb_data);

   // Free-entry count from registered busy only
   always_comb begin
      free_cnt = CNT_W'(ENT_NUM);
      for (int i = 0; i < ENT_NUM; i++) begin
         free_cnt = free_cnt - CNT_W'(busy_reg[i]);
      end
   end

   // Lowest non-busy entry: isolate the lowest zero bit of busy
   assign alloc_oh = ~busy_reg & (busy_reg + ENT_NUM'(1));
   assign alloc_ok = bus.i_wr_en && !(&busy_reg);

`ifdef RS_AGE_SEL_EN
   // age_reg[i][j] = 1 means entry j is older than entry i
   logic [ENT_NUM-1:0] age_reg [ENT_NUM];

   // Age tracking: new entry is younger than everything live; its column is
   // cleared in every other row so stale bits from a previous life vanish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENT_NUM; i++) begin
            age_reg[i] <= '0;
         end
      end else if (alloc_ok && !bus.i_flush) begin
         for (int i = 0; i < ENT_NUM; i++) begin
            if (alloc_oh[i]) begin
               age_reg[i] <= busy_reg;
            end else begin
               age_reg[i] <= age_reg[i] & ~alloc_oh;
            end
         end
      end
   end

   // Oldest-first: a ready entry with no older ready entry
   generate
      for (gi = 0; gi < ENT_NUM; gi++) begin : g_age_sel
         assign sel_oh[gi] = ready[gi] & ~(|(age_reg[gi] & ready));
      end
   endgenerate
`else
   // Lowest-index ready entry: isolate the lowest set bit of ready
   assign sel_oh = ready & (~ready + ENT_NUM'(1));
`endif

   assign iss_vld  = |ready;
   assign iss_fire = iss_vld && bus.i_iss_rdy;

   // Issue mux driven by the one-hot select (registers only)
   always_comb begin
      iss_payload = '0;
      iss_rs1     = '0;
      iss_rs2     = '0;
      iss_rrftag  = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         if (sel_oh[i]) begin
            iss_payload = iss_payload | payload_reg[i];
            iss_rs1     = iss_rs1 | rs1_reg[i];
            iss_rs2     = iss_rs2 | rs2_reg[i];
            iss_rrftag  = iss_rrftag | rrftag_reg[i];
         end
      end
   end

   assign bus.o_full        = &busy_reg;
   assign bus.o_free_cnt    = free_cnt;
   assign bus.o_iss_vld     = iss_vld;
   assign bus.o_iss_payload = iss_payload;
   assign bus.o_iss_rs1     = iss_rs1;
   assign bus.o_iss_rs2     = iss_rs2;
   assign bus.o_iss_rrftag  = iss_rrftag;

   // Entry state: flush beats allocate, issue and wakeup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg    <= '0;
         rs1_vld_reg <= '0;
         rs2_vld_reg <= '0;
         for (int i = 0; i < ENT_NUM; i++) begin
            rs1_reg[i]     <= '0;
            rs2_reg[i]     <= '0;
            payload_reg[i] <= '0;
            rrftag_reg[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < ENT_NUM; i++) begin
            if (bus.i_flush) begin
               busy_reg[i] <= 1'b0;
            end else if (alloc_ok && alloc_oh[i]) begin
               busy_reg[i]    <= 1'b1;
               payload_reg[i] <= bus.i_wr_payload;
               rrftag_reg[i]  <= bus.i_wr_rrftag;
               rs1_vld_reg[i] <= bus.i_wr_rs1_vld | byp1[DATA_W];
               rs2_vld_reg[i] <= bus.i_wr_rs2_vld | byp2[DATA_W];
               rs1_reg[i]     <= (!bus.i_wr_rs1_vld && byp1[DATA_W]) ?
                                 byp1[DATA_W-1:0] : bus.i_wr_rs1;
               rs2_reg[i]     <= (!bus.i_wr_rs2_vld && byp2[DATA_W]) ?
                                 byp2[DATA_W-1:0] : bus.i_wr_rs2;
            end else begin
               if (iss_fire && sel_oh[i]) begin
                  busy_reg[i] <= 1'b0;
               end
               if (busy_reg[i] && !rs1_vld_reg[i] && wake1[i][DATA_W]) begin
                  rs1_vld_reg[i] <= 1'b1;
                  rs1_reg[i]     <= wake1[i][DATA_W-1:0];
               end
               if (busy_reg[i] && !rs2_vld_reg[i] && wake2[i][DATA_W]) begin
                  rs2_vld_reg[i] <= 1'b1;
                  rs2_reg[i]     <= wake2[i][DATA_W-1:0];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: scoreboard bench for rs_alu_station. Expected issues
// are queued as ops are dispatched and popped when the station issues.
// Honours RS_AGE_SEL_EN for the selection-order scenario.
module tb_rs_alu_station;
   localparam int ENT_NUM   = 8;
   localparam int WB_NUM    = 3;
   localparam int DATA_W    = 32;
   localparam int TAG_W     = 6;
   localparam int PAYLOAD_W = 72;

   typedef struct {
      logic [PAYLOAD_W-1:0] payload;
      logic [DATA_W-1:0]    rs1;
      logic [DATA_W-1:0]    rs2;
      logic [TAG_W-1:0]     tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb_q[$];

   rs_alu_station_if #(
      .ENT_NUM(ENT_NUM), .WB_NUM(WB_NUM), .DATA_W(DATA_W),
      .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
   ) bus ();

   rs_alu_station #(
      .ENT_NUM(ENT_NUM), .WB_NUM(WB_NUM), .DATA_W(DATA_W),
      .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [PAYLOAD_W-1:0] p, input logic [DATA_W-1:0] r1,
                           input logic [DATA_W-1:0] r2, input logic [TAG_W-1:0] t);
      exp_t e;
      e.payload = p;
      e.rs1     = r1;
      e.rs2     = r2;
      e.tag     = t;
      sb_q.push_back(e);
   endtask

   task automatic set_wb(input int port, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] data);
      bus.i_wb_vld[port]                  = 1'b1;
      bus.i_wb_tag[port*TAG_W +: TAG_W]   = tag;
      bus.i_wb_data[port*DATA_W +: DATA_W] = data;
   endtask

   task automatic clear_wb();
      bus.i_wb_vld  = '0;
      bus.i_wb_tag  = '0;
      bus.i_wb_data = '0;
   endtask

   task automatic dispatch(input logic [PAYLOAD_W-1:0] p,
                           input logic v1, input logic [DATA_W-1:0] r1,
                           input logic v2, input logic [DATA_W-1:0] r2,
                           input logic [TAG_W-1:0] t);
      bus.i_wr_payload = p;
      bus.i_wr_rs1_vld = v1;
      bus.i_wr_rs1     = r1;
      bus.i_wr_rs2_vld = v2;
      bus.i_wr_rs2     = r2;
      bus.i_wr_rrftag  = t;
      bus.i_wr_en      = 1'b1;
      $display("dispatch payload=0x%0h rs1=%0d:0x%0h rs2=%0d:0x%0h tag=%0d",
               p, v1, r1, v2, r2, t);
      tick();
      bus.i_wr_en = 1'b0;
   endtask

   // Scoreboard: every accepted issue is compared with the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.o_iss_vld && bus.i_iss_rdy) begin
         $display("issue payload=0x%0h rs1=0x%0h rs2=0x%0h tag=%0d",
                  bus.o_iss_payload, bus.o_iss_rs1, bus.o_iss_rs2, bus.o_iss_rrftag);
         if (sb_q.size() == 0) begin
            check("sb_unexpected_issue", 128'(1), 128'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("iss_payload", 128'(bus.o_iss_payload), 128'(e.payload));
            check("iss_rs1", 128'(bus.o_iss_rs1), 128'(e.rs1));
            check("iss_rs2", 128'(bus.o_iss_rs2), 128'(e.rs2));
            check("iss_rrftag", 128'(bus.o_iss_rrftag), 128'(e.tag));
         end
      end
   end

   initial begin
      rst_n            = 1'b0;
      bus.i_flush      = 1'b0;
      bus.i_wr_en      = 1'b0;
      bus.i_wr_payload = '0;
      bus.i_wr_rs1_vld = 1'b0;
      bus.i_wr_rs2_vld = 1'b0;
      bus.i_wr_rs1     = '0;
      bus.i_wr_rs2     = '0;
      bus.i_wr_rrftag  = '0;
      bus.i_iss_rdy    = 1'b0;
      clear_wb();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      settle();
      check("rst_iss_vld", 128'(bus.o_iss_vld), 128'(0));
      check("rst_full", 128'(bus.o_full), 128'(0));
      check("rst_free_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      check("rst_iss_rs1", 128'(bus.o_iss_rs1), 128'(0));
      check("rst_iss_payload", 128'(bus.o_iss_payload), 128'(0));
      tick();

      // Ready op issues the cycle after it is written
      bus.i_iss_rdy = 1'b1;
      push_exp(72'h1, 32'd5, 32'd7, 6'd3);
      dispatch(72'h1, 1'b1, 32'd5, 1'b1, 32'd7, 6'd3);
      settle();
      check("t1_iss_vld", 128'(bus.o_iss_vld), 128'(1));
      tick();
      settle();
      check("t1_free_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      check("t1_iss_vld_after", 128'(bus.o_iss_vld), 128'(0));
      tick();

      // Pending rs1 woken by port 1 two cycles later
      push_exp(72'h2, 32'h1234, 32'h22, 6'd10);
      dispatch(72'h2, 1'b0, 32'd9, 1'b1, 32'h22, 6'd10);
      settle();
      check("t2_pending", 128'(bus.o_iss_vld), 128'(0));
      tick();
      set_wb(1, 6'd9, 32'h1234);
      settle();
      check("t2_no_same_cycle", 128'(bus.o_iss_vld), 128'(0));
      tick();
      clear_wb();
      settle();
      check("t2_iss_vld", 128'(bus.o_iss_vld), 128'(1));
      tick();

      // Dispatch bypass; ports 0 and 2 both match, port 0 wins
      set_wb(0, 6'd4, 32'hAA);
      set_wb(2, 6'd4, 32'hBB);
      push_exp(72'h3, 32'h11, 32'hAA, 6'd12);
      dispatch(72'h3, 1'b1, 32'h11, 1'b0, 32'd4, 6'd12);
      clear_wb();
      settle();
      check("t3_iss_vld", 128'(bus.o_iss_vld), 128'(1));
      tick();

      // Fill, overflow write, flush
      bus.i_iss_rdy = 1'b0;
      for (int i = 0; i < ENT_NUM; i++) begin
         dispatch(72'h100 + 72'(i), 1'b0, 32'd20, 1'b1, 32'(i), 6'(20 + i));
         if (i == 2) begin
            check("t4_free_cnt_part", 128'(bus.o_free_cnt), 128'(ENT_NUM - 3));
         end
      end
      settle();
      check("t4_full", 128'(bus.o_full), 128'(1));
      check("t4_free_cnt_zero", 128'(bus.o_free_cnt), 128'(0));
      check("t4_none_ready", 128'(bus.o_iss_vld), 128'(0));
      tick();
      dispatch(72'hEE, 1'b1, 32'd1, 1'b1, 32'd2, 6'd63);
      settle();
      check("t4_extra_ignored", 128'(bus.o_iss_vld), 128'(0));
      check("t4_extra_cnt", 128'(bus.o_free_cnt), 128'(0));
      tick();
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      settle();
      check("t4_flush_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      check("t4_flush_full", 128'(bus.o_full), 128'(0));
      check("t4_flush_vld", 128'(bus.o_iss_vld), 128'(0));
      tick();
      set_wb(0, 6'd20, 32'h55);
      tick();
      clear_wb();
      settle();
      check("t4_dead_wake", 128'(bus.o_iss_vld), 128'(0));
      tick();
      bus.i_flush = 1'b1;
      dispatch(72'hEF, 1'b1, 32'd1, 1'b1, 32'd2, 6'd62);
      bus.i_flush = 1'b0;
      settle();
      check("t4_flush_beats_wr", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      check("t4_flush_beats_wr_vld", 128'(bus.o_iss_vld), 128'(0));
      tick();

      // Selection order: A in entry 1, B reuses entry 0, both woken together
      dispatch(72'h50, 1'b1, 32'd1, 1'b1, 32'd2, 6'd30);
      dispatch(72'h5A, 1'b0, 32'd40, 1'b1, 32'hA2, 6'd31);
      bus.i_iss_rdy = 1'b1;
      push_exp(72'h50, 32'd1, 32'd2, 6'd30);
      settle();
      tick();
      bus.i_iss_rdy = 1'b0;
      dispatch(72'h5B, 1'b0, 32'd40, 1'b1, 32'hB2, 6'd32);
      set_wb(2, 6'd40, 32'h4040);
      tick();
      clear_wb();
`ifdef RS_AGE_SEL_EN
      push_exp(72'h5A, 32'h4040, 32'hA2, 6'd31);
      push_exp(72'h5B, 32'h4040, 32'hB2, 6'd32);
`else
      push_exp(72'h5B, 32'h4040, 32'hB2, 6'd32);
      push_exp(72'h5A, 32'h4040, 32'hA2, 6'd31);
`endif
      // Hold off the ALU: nothing freed, offer stays up
      for (int c = 0; c < 5; c++) begin
         settle();
         check("t6_hold_vld", 128'(bus.o_iss_vld), 128'(1));
         check("t6_hold_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM - 2));
         check("t6_hold_tag", 128'(bus.o_iss_rrftag), 128'(sb_q[0].tag));
         tick();
      end
      bus.i_iss_rdy = 1'b1;
      settle();
      tick();
      settle();
      tick();
      bus.i_iss_rdy = 1'b0;
      settle();
      check("t5_drained_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      check("t5_drained_vld", 128'(bus.o_iss_vld), 128'(0));
      tick();

      // Asynchronous reset mid-cycle clears outputs without a clock edge
      dispatch(72'h60, 1'b1, 32'h66, 1'b1, 32'h77, 6'd5);
      settle();
      check("t6_pre_rst_vld", 128'(bus.o_iss_vld), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_vld", 128'(bus.o_iss_vld), 128'(0));
      check("t6_rst_rs1", 128'(bus.o_iss_rs1), 128'(0));
      check("t6_rst_payload", 128'(bus.o_iss_payload), 128'(0));
      check("t6_rst_cnt", 128'(bus.o_free_cnt), 128'(ENT_NUM));
      #1 rst_n = 1'b1;
      tick();
      bus.i_iss_rdy = 1'b1;
      push_exp(72'h61, 32'h61, 32'h62, 6'd7);
      dispatch(72'h61, 1'b1, 32'h61, 1'b1, 32'h62, 6'd7);
      settle();
      check("t6_post_rst_vld", 128'(bus.o_iss_vld), 128'(1));
      tick();
      settle();

      check("sb_all_issued", 128'(sb_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
